// File: rtl/audio_pkg.sv
// Shared types and constants for the audio playback sequencer.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFILL  = 2'd1,
        ST_PLAY     = 2'd2,
        ST_STOPPING = 2'd3
    } stream_state_t;

    localparam int UNDERRUN_CNT_W = 16;

    // Mid-scale code of unsigned PCM, i.e. the DC level heard as silence.
    function automatic logic [31:0] SILENCE(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: fires one tick every SAMPLE_DIV enabled cycles.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 3125
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/audio_stream_ctrl.sv
// Playback sequencer: paces FIFO reads at the sample rate, manages prefill,
// underrun recovery, low-watermark refill bursts and flush on stop.
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WIDTH       = 8,
    parameter int SAMPLE_DIV  = 3125,
    parameter int PREFILL_LVL = 512,
    parameter int LOW_WM      = 256,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      play,
    input  logic                      stop,
    input  logic [LW-1:0]             fifo_fill_level,
    input  logic                      fifo_empty,
    input  logic [WIDTH-1:0]          fifo_rd_data,
    input  logic                      fifo_rd_valid,
    output logic                      fifo_rd_en,
    output logic                      fifo_flush,
    output logic                      refill_req,
    input  logic                      refill_ack,
    input  logic                      refill_done,
    output logic [WIDTH-1:0]          sample_out,
    output logic                      sample_valid,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt,
    output logic [1:0]                state
);

    localparam logic [LW-1:0]             PREFILL_L = LW'(PREFILL_LVL);
    localparam logic [LW-1:0]             LOW_L     = LW'(LOW_WM);
    localparam logic [WIDTH-1:0]          SILENCE_V = WIDTH'(SILENCE(WIDTH));
    localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX   = '1;

    stream_state_t             state_q;
    logic                      rd_en_q;
    logic                      flush_q;
    logic                      req_q;
    logic                      busy_q;
    logic                      busy_d;
    logic [WIDTH-1:0]          sample_q;
    logic                      valid_q;
    logic                      underrun_q;
    logic [UNDERRUN_CNT_W-1:0] ucnt_q;
    logic                      in_play;
    logic                      tick;
    logic                      fill_active;

    assign in_play     = (state_q == ST_PLAY);
    assign fill_active = (state_q == ST_PREFILL) || (state_q == ST_PLAY);

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .en     (in_play),
        .clr    (!in_play),
        .tick   (tick)
    );

    // Outstanding-burst flag; a done in the same cycle as an ack leaves it clear.
    always_comb begin
        busy_d = busy_q;
        if (refill_done) begin
            busy_d = 1'b0;
        end else if (refill_ack && req_q) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            rd_en_q    <= 1'b0;
            flush_q    <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            sample_q   <= SILENCE_V;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            rd_en_q    <= 1'b0;
            flush_q    <= 1'b0;
            underrun_q <= 1'b0;
            valid_q    <= fifo_rd_valid;
            busy_q     <= busy_d;
            if (fifo_rd_valid) begin
                sample_q <= fifo_rd_data;
            end

            // A pending request is withdrawn whenever we leave the fill states.
            if (fill_active && !stop) begin
                if (req_q && refill_ack) begin
                    req_q <= 1'b0;
                end else if (!req_q && !busy_q && (fifo_fill_level <= LOW_L)) begin
                    req_q <= 1'b1;
                end
            end else begin
                req_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (play && !stop) begin
                        state_q <= ST_PREFILL;
                    end
                end
                ST_PREFILL: begin
                    if (stop) begin
                        state_q <= ST_STOPPING;
                        flush_q <= !busy_d;
                    end else if (fifo_fill_level >= PREFILL_L) begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        state_q <= ST_STOPPING;
                        flush_q <= !busy_d;
                    end else if (tick) begin
                        if (!fifo_empty) begin
                            rd_en_q <= 1'b1;
                        end else begin
                            underrun_q <= 1'b1;
                            state_q    <= ST_PREFILL;
                            if (ucnt_q != CNT_MAX) begin
                                ucnt_q <= ucnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_STOPPING: begin
                    // Flush is raised on the final STOPPING cycle, IDLE follows.
                    if (flush_q) begin
                        state_q  <= ST_IDLE;
                        sample_q <= SILENCE_V;
                    end else if (!busy_d) begin
                        flush_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_rd_en   = rd_en_q;
    assign fifo_flush   = flush_q;
    assign refill_req   = req_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Bench for audio_stream_ctrl: FIFO read-data scoreboard, handshake/FSM checks,
// plus a fast-divider instance that drives the underrun counter into saturation.
module tb_audio_stream_ctrl;

    localparam int DIV = 3125;
    localparam int LW  = 11;

    logic CLK;
    int   cyc;
    int   checks;
    int   errors;

    logic          rst_n, play, stop, empty, rd_valid, ack, done;
    logic [LW-1:0] fill;
    logic [7:0]    rd_data;
    logic          rd_en, flush, req, sv, ur;
    logic [7:0]    sample;
    logic [15:0]   ucnt;
    logic [1:0]    st;

    logic          s_rst_n, s_play, s_stop, s_empty, s_rd_valid, s_ack, s_done;
    logic [LW-1:0] s_fill;
    logic [7:0]    s_rd_data;
    logic          s_rd_en, s_flush, s_req, s_sv, s_ur;
    logic [7:0]    s_sample;
    logic [15:0]   s_ucnt;
    logic [1:0]    s_st;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] last_data;
    logic [7:0] next_data;
    logic       rd_pend;

    audio_stream_ctrl dut (
        .CLK(CLK), .RESET_N(rst_n), .play(play), .stop(stop),
        .fifo_fill_level(fill), .fifo_empty(empty), .fifo_rd_data(rd_data),
        .fifo_rd_valid(rd_valid), .fifo_rd_en(rd_en), .fifo_flush(flush),
        .refill_req(req), .refill_ack(ack), .refill_done(done),
        .sample_out(sample), .sample_valid(sv), .underrun(ur),
        .underrun_cnt(ucnt), .state(st)
    );

    audio_stream_ctrl #(.SAMPLE_DIV(1)) dut_sat (
        .CLK(CLK), .RESET_N(s_rst_n), .play(s_play), .stop(s_stop),
        .fifo_fill_level(s_fill), .fifo_empty(s_empty), .fifo_rd_data(s_rd_data),
        .fifo_rd_valid(s_rd_valid), .fifo_rd_en(s_rd_en), .fifo_flush(s_flush),
        .refill_req(s_req), .refill_ack(s_ack), .refill_done(s_done),
        .sample_out(s_sample), .sample_valid(s_sv), .underrun(s_ur),
        .underrun_cnt(s_ucnt), .state(s_st)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_play();
        play = 1'b1;
        cyc_n(1);
        play = 1'b0;
    endtask

    task automatic wait_rd(input int budget, output int c, output logic ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (rd_en) begin
                c  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ur(input int budget, output int c, output logic ok, output int rd_cnt);
        ok     = 1'b0;
        c      = 0;
        rd_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (rd_en) rd_cnt++;
            if (ur) begin
                c  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // FIFO model with one-cycle read latency; expected samples go to the scoreboard.
    initial begin
        exp_t e;
        rd_pend   = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 8'h00;
        next_data = 8'h11;
        last_data = 8'h80;
        forever begin
            @(negedge CLK);
            if (!rst_n) begin
                rd_pend  = 1'b0;
                rd_valid = 1'b0;
                sb_q.delete();
            end else begin
                if (sv) begin
                    check_eq("sb_nonempty", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check_eq("sample_data", sample, e.data);
                        check_eq("sample_cycle", cyc, e.cyc);
                    end
                end
                rd_valid = rd_pend;
                if (rd_pend) begin
                    rd_data   = next_data;
                    e.data    = next_data;
                    e.cyc     = cyc + 1;
                    sb_q.push_back(e);
                    last_data = next_data;
                    next_data = next_data + 8'd37;
                    if (next_data == 8'h80) next_data = next_data + 8'd1;
                end
                rd_pend = rd_en;
            end
        end
    end

    task automatic main_seq();
        int   e, e2, c1, c2, c3, u, rdn;
        logic ok, hold;

        rst_n = 1'b0; play = 1'b0; stop = 1'b0; fill = '0;
        empty = 1'b0; ack = 1'b0; done = 1'b0;
        cyc_n(3);
        check_eq("rst_state", st, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_flush", flush, 0);
        check_eq("rst_req", req, 0);
        check_eq("rst_sv", sv, 0);
        check_eq("rst_underrun", ur, 0);
        check_eq("rst_ucnt", ucnt, 0);
        check_eq("rst_sample", sample, 8'h80);
        rst_n = 1'b1;
        cyc_n(1);

        stop = 1'b1;
        cyc_n(1);
        stop = 1'b0;
        check_eq("idle_stop_state", st, 0);
        check_eq("idle_stop_flush", flush, 0);
        play = 1'b1; stop = 1'b1;
        cyc_n(1);
        play = 1'b0; stop = 1'b0;
        check_eq("play_stop_idle", st, 0);

        fill = 11'd511;
        pulse_play();
        check_eq("prefill_state", st, 1);
        cyc_n(5);
        check_eq("prefill_hold", st, 1);
        fill = 11'd512;
        cyc_n(1);
        check_eq("play_entry", st, 2);
        e = cyc;
        wait_rd(DIV + 10, c1, ok);
        check_eq("rd1_seen", ok, 1);
        check_eq("rd1_delay", c1 - e, DIV);
        cyc_n(1);
        check_eq("rd_en_single", rd_en, 0);
        wait_rd(DIV + 10, c2, ok);
        check_eq("rd2_seen", ok, 1);
        check_eq("rd_period", c2 - c1, DIV);
        cyc_n(4);
        check_eq("sample_after_rd", sample, last_data);

        fill = 11'd256;
        cyc_n(1);
        check_eq("req_rise", req, 1);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc_n(1);
            if (!req) hold = 1'b0;
        end
        check_eq("req_hold", hold, 1);
        ack = 1'b1;
        cyc_n(1);
        ack = 1'b0;
        check_eq("req_fall_on_ack", req, 0);
        fill = 11'd100;
        cyc_n(5);
        check_eq("no_req_while_busy", req, 0);
        done = 1'b1;
        cyc_n(1);
        done = 1'b0;
        check_eq("no_req_at_done", req, 0);
        cyc_n(1);
        check_eq("req_after_done", req, 1);
        ack = 1'b1;
        cyc_n(1);
        ack = 1'b0;
        fill = 11'd300;

        wait_rd(DIV + 10, c3, ok);
        check_eq("rd3_seen", ok, 1);
        check_eq("rd3_period", c3 - c2, DIV);
        empty = 1'b1;
        wait_ur(DIV + 10, u, ok, rdn);
        check_eq("ur_seen", ok, 1);
        check_eq("ur_delay", u - c3, DIV);
        check_eq("ur_state", st, 1);
        check_eq("ur_cnt", ucnt, 1);
        check_eq("ur_no_rd", rdn, 0);
        cyc_n(1);
        check_eq("ur_single", ur, 0);
        check_eq("ur_rd_en", rd_en, 0);
        cyc_n(2);
        check_eq("ur_sample_kept", sample, last_data);
        empty = 1'b0;

        stop = 1'b1;
        cyc_n(1);
        stop = 1'b0;
        check_eq("stop_busy_state", st, 3);
        check_eq("stop_busy_flush", flush, 0);
        cyc_n(5);
        check_eq("stop_wait_state", st, 3);
        check_eq("stop_wait_flush", flush, 0);
        done = 1'b1;
        cyc_n(1);
        done = 1'b0;
        check_eq("flush_pulse", flush, 1);
        check_eq("flush_last_stopping", st, 3);
        cyc_n(1);
        check_eq("idle_after_flush", st, 0);
        check_eq("flush_single", flush, 0);
        check_eq("silence_after_stop", sample, 8'h80);

        fill = 11'd512;
        pulse_play();
        cyc_n(1);
        check_eq("play_entry2", st, 2);
        e2 = cyc;
        fill = 11'd200;
        cyc_n(2);
        check_eq("req_unacked", req, 1);
        cyc_n(e2 + DIV - 1 - cyc);
        stop = 1'b1;
        cyc_n(1);
        stop = 1'b0;
        check_eq("stop_tick_no_rd", rd_en, 0);
        check_eq("stop_tick_state", st, 3);
        check_eq("stop_tick_flush", flush, 1);
        check_eq("req_withdrawn", req, 0);
        cyc_n(1);
        check_eq("stop_tick_idle", st, 0);
        check_eq("stop_tick_no_rd2", rd_en, 0);

        fill = 11'd512;
        pulse_play();
        cyc_n(1);
        fill = 11'd200;
        cyc_n(2);
        ack = 1'b1;
        cyc_n(1);
        ack = 1'b0;
        fill = 11'd300;
        wait_rd(DIV + 10, c1, ok);
        check_eq("rd4_seen", ok, 1);
        cyc_n(3);
        check_eq("pre_reset_sample", sample, last_data);
        @(posedge CLK);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_state", st, 0);
        check_eq("arst_rd_en", rd_en, 0);
        check_eq("arst_flush", flush, 0);
        check_eq("arst_req", req, 0);
        check_eq("arst_sv", sv, 0);
        check_eq("arst_underrun", ur, 0);
        check_eq("arst_ucnt", ucnt, 0);
        check_eq("arst_sample", sample, 8'h80);
        cyc_n(2);
        rst_n = 1'b1;
        fill = 11'd100;
        pulse_play();
        check_eq("post_rst_prefill", st, 1);
        cyc_n(1);
        check_eq("post_rst_req", req, 1);
    endtask

    task automatic sat_seq();
        int n, rdseen;
        s_rst_n = 1'b0; s_play = 1'b0; s_stop = 1'b0; s_fill = 11'd600;
        s_empty = 1'b1; s_ack = 1'b0; s_done = 1'b0;
        s_rd_data = 8'h00; s_rd_valid = 1'b0;
        cyc_n(3);
        s_rst_n = 1'b1;
        cyc_n(1);
        s_play = 1'b1;
        cyc_n(1);
        s_play = 1'b0;
        n = 0;
        rdseen = 0;
        for (int i = 0; i < 140000 && n < 65538; i++) begin
            @(negedge CLK);
            if (s_rd_en) rdseen++;
            if (s_ur) begin
                n++;
                if (n == 1)     check_eq("sat_first", s_ucnt, 1);
                if (n == 1000)  check_eq("sat_mid", s_ucnt, 1000);
                if (n == 65535) check_eq("sat_max", s_ucnt, 16'hFFFF);
            end
        end
        check_eq("sat_pulses", n, 65538);
        check_eq("sat_hold", s_ucnt, 16'hFFFF);
        check_eq("sat_no_rd", rdseen, 0);
        check_eq("sat_state", s_st, 1);
        check_eq("sat_req", s_req, 0);
        check_eq("sat_flush", s_flush, 0);
        check_eq("sat_sv", s_sv, 0);
        check_eq("sat_sample", s_sample, 8'h80);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fork
            main_seq();
            sat_seq();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
